// File: rtl/exe_dmem_req_pkg.sv
// Shared constants for the execute-stage data-memory request engine:
// FSM encodings, bus size codes, the ALE exception code and the alignment rule.
package exe_dmem_req_pkg;

    localparam logic [2:0] DMEM_IDLE  = 3'd0;
    localparam logic [2:0] DMEM_REQ   = 3'd1;
    localparam logic [2:0] DMEM_WAIT  = 3'd2;
    localparam logic [2:0] DMEM_DONE  = 3'd3;
    localparam logic [2:0] DMEM_DRAIN = 3'd4;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // Exception code EX packs into its exception bundle when ale is reported.
    localparam logic [5:0] ECODE_ALE = 6'h09;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic mis;
        mis = 1'b1;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = addrLo[0];
            MEM_SIZE_W: mis = (addrLo != 2'b00);
            default:    mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exe_dmem_req_wstrb_gen.sv
// Combinational store formatter: byte strobes, lane-replicated write data
// and the misalignment flag from size and the low address bits.
module exe_dmem_req_wstrb_gen
    import exe_dmem_req_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdataRep_o,
    output logic        ale_o
);

    always_comb begin
        wstrb_o    = 4'b0000;
        wdataRep_o = wdata_i;
        case (size_i)
            MEM_SIZE_B: begin
                wstrb_o    = 4'b0001 << addrLo_i;
                wdataRep_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                wstrb_o    = 4'b0011 << {addrLo_i[1], 1'b0};
                wdataRep_o = {2{wdata_i[15:0]}};
            end
            MEM_SIZE_W: begin
                wstrb_o    = 4'b1111;
                wdataRep_o = wdata_i;
            end
            default: begin
                wstrb_o    = 4'b0000;
                wdataRep_o = wdata_i;
            end
        endcase
    end

    assign ale_o = isMisaligned(size_i, addrLo_i);

endmodule

// File: rtl/exe_dmem_req.sv
// Execute-stage data-memory request engine: issues one SRAM-like bus access
// per EX memory op, reports ALE/done, and cancels or drains on pipeline flush.
module exe_dmem_req
    import exe_dmem_req_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_en,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              out_accept,
    output logic              busy,
    output logic              done,
    output logic              ale,
    output logic [DATA_W-1:0] rdata,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    logic [2:0]        state_q, state_d;
    logic              reqWe_q;
    logic [1:0]        reqSize_q;
    logic [ADDR_W-1:0] reqAddr_q;
    logic [3:0]        reqWstrb_q;
    logic [DATA_W-1:0] reqWdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [3:0]        genWstrb;
    logic [DATA_W-1:0] genWdata;
    logic              genAle;
    logic              isIdle;
    logic              latchReq;
    logic              captureData;

    exe_dmem_req_wstrb_gen uWstrbGen (
        .size_i     (req_size),
        .addrLo_i   (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .wstrb_o    (genWstrb),
        .wdataRep_o (genWdata),
        .ale_o      (genAle)
    );

    // Flush is evaluated before any bus handshake in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (!ex_en && req_valid && !genAle) state_d = DMEM_REQ;
            end
            DMEM_REQ: begin
                if (ex_en)                  state_d = data_sram_addr_ok ? DMEM_DRAIN : DMEM_IDLE;
                else if (data_sram_addr_ok) state_d = DMEM_WAIT;
            end
            DMEM_WAIT: begin
                if (ex_en)                  state_d = data_sram_data_ok ? DMEM_IDLE : DMEM_DRAIN;
                else if (data_sram_data_ok) state_d = DMEM_DONE;
            end
            DMEM_DONE: begin
                if (ex_en || out_accept) state_d = DMEM_IDLE;
            end
            DMEM_DRAIN: begin
                if (data_sram_data_ok) state_d = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    assign isIdle      = (state_q == DMEM_IDLE);
    assign latchReq    = isIdle && (state_d == DMEM_REQ);
    assign captureData = (state_q == DMEM_WAIT) && data_sram_data_ok && !ex_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The bus side only ever sees these registers, so EX may change its
    // operands freely once the access has been latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqWe_q    <= 1'b0;
            reqSize_q  <= 2'b00;
            reqAddr_q  <= '0;
            reqWstrb_q <= 4'b0000;
            reqWdata_q <= '0;
        end else if (latchReq) begin
            reqWe_q    <= req_we;
            reqSize_q  <= req_size;
            reqAddr_q  <= req_addr;
            reqWstrb_q <= req_we ? genWstrb : 4'b0000;
            reqWdata_q <= genWdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (captureData) begin
            rdata_q <= reqWe_q ? '0 : data_sram_rdata;
        end
    end

    assign busy = !isIdle;
    assign ale  = isIdle && req_valid && genAle && !ex_en;
    assign done = (state_q == DMEM_DONE) || ale;
    assign rdata = (state_q == DMEM_DONE) ? rdata_q : '0;

    assign data_sram_req   = (state_q == DMEM_REQ);
    assign data_sram_wr    = reqWe_q;
    assign data_sram_size  = reqSize_q;
    assign data_sram_wstrb = reqWstrb_q;
    assign data_sram_addr  = reqAddr_q;
    assign data_sram_wdata = reqWdata_q;

endmodule

// File: tb/tb_exe_dmem_req.sv
// Testbench for exe_dmem_req: directed scenarios with literal expectations,
// then randomized EX/bus traffic checked every cycle against a transaction model.
module tb_exe_dmem_req;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        out_accept = 1'b0;
    logic        busy, done, ale;
    logic [31:0] rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;

    int checks = 0;
    int fails  = 0;

    exe_dmem_req dut (
        .clk               (clk),
        .rst               (rst),
        .ex_en             (ex_en),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .out_accept        (out_accept),
        .busy              (busy),
        .done              (done),
        .ale               (ale),
        .rdata             (rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    // Transaction model: which phase the single in-flight access is in.
    logic        mAddrPend = 1'b0;
    logic        mDataPend = 1'b0;
    logic        mKilled   = 1'b0;
    logic        mResult   = 1'b0;
    logic [31:0] mRdata = '0;
    logic [31:0] mAddr  = '0;
    logic [31:0] mWdata = '0;
    logic        mWe    = 1'b0;
    logic [1:0]  mSize  = 2'b00;

    function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return (addr % 2) != 0;
            2'd2:    return (addr % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] expStrb(input logic [1:0] size, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        case (size)
            2'd0:    return 4'(1 << lane);
            2'd1:    return (lane >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expData(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return (wd & 32'h0000_00FF) * 32'h0101_0101;
            2'd1:    return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic mIdle();
        return !(mAddrPend || mDataPend || mResult);
    endfunction

    function automatic logic expAle();
        return mIdle() && req_valid && !ex_en && misaligned(req_size, req_addr);
    endfunction

    function automatic logic expDone();
        return mResult || expAle();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mAddrPend <= 1'b0;
            mDataPend <= 1'b0;
            mKilled   <= 1'b0;
            mResult   <= 1'b0;
        end else if (mIdle()) begin
            if (req_valid && !ex_en && !misaligned(req_size, req_addr)) begin
                mAddrPend <= 1'b1;
                mWe       <= req_we;
                mSize     <= req_size;
                mAddr     <= req_addr;
                mWdata    <= req_wdata;
            end
        end else if (mAddrPend) begin
            if (data_sram_addr_ok) begin
                mAddrPend <= 1'b0;
                mDataPend <= 1'b1;
                mKilled   <= ex_en;
            end else if (ex_en) begin
                mAddrPend <= 1'b0;
            end
        end else if (mDataPend) begin
            if (data_sram_data_ok) begin
                mDataPend <= 1'b0;
                mKilled   <= 1'b0;
                if (!mKilled && !ex_en) begin
                    mResult <= 1'b1;
                    mRdata  <= mWe ? 32'h0 : data_sram_rdata;
                end
            end else if (ex_en) begin
                mKilled <= 1'b1;
            end
        end else if (out_accept || ex_en) begin
            mResult <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(!mIdle()));
        checkOutput("done", 32'(done), 32'(expDone()));
        checkOutput("ale", 32'(ale), 32'(expAle()));
        checkOutput("rdata", rdata, mResult ? mRdata : 32'h0);
        checkOutput("req", 32'(data_sram_req), 32'(mAddrPend));
        if (mAddrPend) begin
            checkOutput("bus wr", 32'(data_sram_wr), 32'(mWe));
            checkOutput("bus size", 32'(data_sram_size), 32'(mSize));
            checkOutput("bus addr", data_sram_addr, mAddr);
            checkOutput("bus wstrb", 32'(data_sram_wstrb), mWe ? 32'(expStrb(mSize, mAddr)) : 32'h0);
            if (mWe) checkOutput("bus wdata", data_sram_wdata, expData(mSize, mWdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic aok, input logic dok, input logic [31:0] rd,
                                 input logic acc, input logic ex);
        req_valid         = v;
        req_we            = we;
        req_size          = sz;
        req_addr          = addr;
        req_wdata         = wd;
        data_sram_addr_ok = aok;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        out_accept        = acc;
        ex_en             = ex;
    endtask

    // One complete access with minimum latency; the result is held for holdCycles before accept.
    task automatic busTxn(input string tag, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [3:0] xStrb, input logic [31:0] xWdata,
                          input logic [31:0] xRdata, input int holdCycles);
        applyStimulus(1'b1, we, sz, addr, wd, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput({tag, " req before issue"}, 32'(data_sram_req), 32'h0);
        tick();
        checkOutput({tag, " req"}, 32'(data_sram_req), 32'h1);
        checkOutput({tag, " size"}, 32'(data_sram_size), 32'(sz));
        checkOutput({tag, " wr"}, 32'(data_sram_wr), 32'(we));
        checkOutput({tag, " addr"}, data_sram_addr, addr);
        checkOutput({tag, " wstrb"}, 32'(data_sram_wstrb), 32'(xStrb));
        if (we) checkOutput({tag, " wdata"}, data_sram_wdata, xWdata);
        applyStimulus(1'b1, we, sz, addr, wd, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, " req after addr_ok"}, 32'(data_sram_req), 32'h0);
        checkOutput({tag, " done in wait"}, 32'(done), 32'h0);
        applyStimulus(1'b1, we, sz, addr, wd, 1'b0, 1'b1, rd, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, we, sz, addr, wd, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i <= holdCycles; i++) begin
            checkOutput({tag, " done"}, 32'(done), 32'h1);
            checkOutput({tag, " rdata"}, rdata, xRdata);
            if (i < holdCycles) tick();
        end
        applyStimulus(1'b1, we, sz, addr, wd, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic aleCase(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] addr);
        applyStimulus(1'b1, we, sz, addr, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput({tag, " done"}, 32'(done), 32'h1);
        checkOutput({tag, " ale"}, 32'(ale), 32'h1);
        checkOutput({tag, " req"}, 32'(data_sram_req), 32'h0);
        tick();
        checkOutput({tag, " req held off"}, 32'(data_sram_req), 32'h0);
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
        applyStimulus(1'b1, we, sz, addr, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    logic        outstanding = 1'b0;
    int          delay = 0;
    logic        lastReq = 1'b0;
    logic        lastDone = 1'b0;
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    initial begin
        checkOutput("model strb byte lane3", 32'(expStrb(2'd0, 32'h3)), 32'h8);
        checkOutput("model strb half upper", 32'(expStrb(2'd1, 32'h2)), 32'hC);
        checkOutput("model data byte", expData(2'd0, 32'h1234_56A5), 32'hA5A5_A5A5);
        checkOutput("model data half", expData(2'd1, 32'hABCD_1234), 32'h1234_1234);
        checkOutput("model ale word", 32'(misaligned(2'd2, 32'h102)), 32'h1);
        checkOutput("model ale half", 32'(misaligned(2'd1, 32'h102)), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset req", 32'(data_sram_req), 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();

        busTxn("LW", 1'b0, 2'd2, 32'h1C00_0104, 32'h0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'hDEAD_BEEF, 3);
        busTxn("SB", 1'b1, 2'd0, 32'h1C00_0103, 32'h0000_00A5, 32'hFFFF_FFFF, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0);
        busTxn("SH", 1'b1, 2'd1, 32'h1C00_0102, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0, 0);
        busTxn("SB0", 1'b1, 2'd0, 32'h1C00_0110, 32'hFFFF_FF3C, 32'h0, 4'b0001, 32'h3C3C_3C3C, 32'h0, 0);

        aleCase("LH misaligned", 1'b0, 2'd1, 32'h1C00_0101);
        aleCase("SW misaligned", 1'b1, 2'd2, 32'h1C00_0102);
        aleCase("size3", 1'b0, 2'd3, 32'h1C00_0100);

        // addr_ok withheld, then cancelled by flush before acceptance
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall req", 32'(data_sram_req), 32'h1);
            checkOutput("stall addr", data_sram_addr, 32'h1C00_0200);
            checkOutput("stall size", 32'(data_sram_size), 32'h2);
            checkOutput("stall wstrb", 32'(data_sram_wstrb), 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("cancel req", 32'(data_sram_req), 32'h0);
        checkOutput("cancel busy", 32'(busy), 32'h0);
        checkOutput("cancel done", 32'(done), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // Flush while waiting for data: drain, and hold off the next load
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0300, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("drain busy", 32'(busy), 32'h1);
        checkOutput("drain req", 32'(data_sram_req), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("drain hold busy", 32'(busy), 32'h1);
            checkOutput("drain hold done", 32'(done), 32'h0);
            checkOutput("drain hold req", 32'(data_sram_req), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
        tick();
        checkOutput("drain end busy", 32'(busy), 32'h0);
        checkOutput("drain end done", 32'(done), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("post drain req", 32'(data_sram_req), 32'h1);
        checkOutput("post drain addr", data_sram_addr, 32'h1C00_0304);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        tick();
        checkOutput("post drain rdata", rdata, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C00_0304, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset while a store waits for its ack
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h1C00_0400, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h1C00_0400, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre-reset busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async busy", 32'(busy), 32'h0);
        checkOutput("async wr", 32'(data_sram_wr), 32'h0);
        checkOutput("async addr", data_sram_addr, 32'h0);
        checkOutput("async wstrb", 32'(data_sram_wstrb), 32'h0);
        checkOutput("async wdata", data_sram_wdata, 32'h0);
        checkOutput("async size", 32'(data_sram_size), 32'h0);
        tick();
        rst = 1'b0;

        // Randomized EX and bus traffic within the bus contract
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (data_sram_data_ok) outstanding = 1'b0;
            if (lastReq && data_sram_addr_ok) begin
                outstanding = 1'b1;
                delay = int'($urandom_range(0, 3));
            end
            if (ex_en) req_valid = 1'b0;
            else if (lastDone && out_accept) req_valid = 1'b0;

            ex_en      = ($urandom_range(0, 19) == 0);
            out_accept = ($urandom_range(0, 2) != 0);
            if (!req_valid && mIdle() && ($urandom_range(0, 1) == 1)) begin
                rSize = 2'($urandom_range(0, 3));
                rAddr = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (rSize == 2'd1) rAddr[0] = 1'b0;
                    else if (rSize == 2'd2) rAddr[1:0] = 2'b00;
                end
                req_valid = 1'b1;
                req_we    = 1'($urandom_range(0, 1));
                req_size  = rSize;
                req_addr  = rAddr;
                req_wdata = $urandom;
            end
            data_sram_rdata = $urandom;
            if (outstanding && delay == 0) begin
                data_sram_data_ok = 1'b1;
            end else begin
                data_sram_data_ok = 1'b0;
                if (outstanding) delay--;
            end
            data_sram_addr_ok = mAddrPend && !outstanding && ($urandom_range(0, 2) != 0);
            lastReq  = mAddrPend;
            lastDone = expDone();
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
